// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling by a plain clock count,
// one-cycle valid / frame_err pulses, single frame_err per held-low break.
module uart_rx #(
    parameter int CLOCK_RATE     = 10,
    parameter int BAUD_RATE      = 1,
    parameter int CLOCKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    generate
        if (CLOCKS_PER_BIT < 4) begin : g_bad_cpb
            $error("uart_rx: CLOCKS_PER_BIT must be >= 4");
        end
    endgenerate

    localparam int              CW      = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0]   HALF_M1 = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   FULL_M1 = CW'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            rs;

    assign rs = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        sync_d  = {sync_q[0], rx};
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rs) begin
                    state_d = S_START;
                    cnt_d   = HALF_M1;
                    bit_d   = '0;
                end
            end
            S_START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rs) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                    cnt_d   = FULL_M1;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rs, shift_q[7:1]};
                    cnt_d   = FULL_M1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rs) begin
                    state_d = S_IDLE;
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end else begin
                    state_d = S_BREAK;
                    ferr_d  = 1'b1;
                end
            end
            S_BREAK: begin
                if (rs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, glitch / reset sequences, and random frames
// checked against a timing-formula model of when and what the receiver must report.
module tb_uart_rx;
    localparam int CPB     = 10;
    localparam int LATENCY = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(
        .CLOCK_RATE(10),
        .BAUD_RATE (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int busy_cnt = 0;

    typedef struct {
        int         cyc;
        bit         is_valid;
        logic [7:0] d;
    } ev_t;
    ev_t evq[$];
    int  ev_rd = 0;

    typedef struct {
        logic [7:0] b;
        bit         stop_b;
        int         low_hold;
        int         gap;
        bit         exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Cycle k is the clock period ending at posedge k, so the current one is edge_cnt+1.
    always @(negedge clk) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (valid || frame_err) begin
            evq.push_back('{edge_cnt + 1, valid, data});
            chk("valid_ferr_exclusive", int'(valid && frame_err), 0);
            if (valid) chk("busy_low_with_valid", int'(busy), 0);
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_low(input int n);
        rx = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Frame whose start bit is first sampled at posedge n_start.
    task automatic send_frame(input logic [7:0] b, input bit stop_b, output int n_start);
        rx      = 1'b0;
        n_start = edge_cnt + 1;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic expect_event(input string name, input int n_start, input bit exp_valid,
                                input logic [7:0] exp_data, output int got_cyc);
        int  n_new;
        ev_t e;
        n_new   = evq.size() - ev_rd;
        got_cyc = -1;
        chk({name, " event_count"}, n_new, 1);
        if (n_new > 0) begin
            e       = evq[ev_rd];
            got_cyc = e.cyc;
            chk({name, " cycle"}, e.cyc, n_start + LATENCY);
            chk({name, " is_valid"}, int'(e.is_valid), int'(exp_valid));
            chk({name, " data"}, int'(e.d), int'(exp_data));
        end
        ev_rd = evq.size();
    endtask

    vec_t       vecs[6];
    int         n_start;
    int         got_cyc[6];
    int         gc;
    int         b0;
    logic [7:0] last_good;
    logic [7:0] rb;
    bit         rstop;

    initial begin
        vecs[0] = '{8'h48, 1'b1, 0,  10, 1'b1, 8'h48};
        vecs[1] = '{8'h55, 1'b0, 50, 10, 1'b0, 8'h48};
        vecs[2] = '{8'hA3, 1'b1, 0,  10, 1'b1, 8'hA3};
        vecs[3] = '{8'h00, 1'b1, 0,  0,  1'b1, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 0,  10, 1'b1, 8'hFF};
        vecs[5] = '{8'h81, 1'b0, 0,  10, 1'b0, 8'hFF};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset data", int'(data), 0);
        chk("reset valid", int'(valid), 0);
        chk("reset frame_err", int'(frame_err), 0);
        chk("reset busy", int'(busy), 0);
        rst = 1'b0;
        idle(5);

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].b, vecs[i].stop_b, n_start);
            expect_event($sformatf("vec%0d", i), n_start, vecs[i].exp_valid, vecs[i].exp_data, gc);
            got_cyc[i] = gc;
            chk($sformatf("vec%0d data_port", i), int'(data), int'(vecs[i].exp_data));
            $display("vec%0d byte=%02h stop=%0d start=%0d event_cycle=%0d data=%02h",
                     i, vecs[i].b, vecs[i].stop_b, n_start, gc, data);
            if (vecs[i].low_hold > 0) hold_low(vecs[i].low_hold);
            if (vecs[i].gap > 0) idle(vecs[i].gap);
        end
        chk("zero_gap spacing", got_cyc[4] - got_cyc[3], 10 * CPB);
        last_good = 8'hFF;

        // Short low glitch: busy must rise, then drop with no pulse.
        b0 = busy_cnt;
        hold_low(3);
        idle(30);
        chk("glitch busy_seen", int'(busy_cnt > b0), 1);
        chk("glitch busy_after", int'(busy), 0);
        chk("glitch no_event", evq.size() - ev_rd, 0);
        chk("glitch data", int'(data), int'(last_good));
        $display("glitch busy_cycles=%0d data=%02h", busy_cnt - b0, data);

        // Reset in the middle of data bit 3 of 0x3C; transmitter abandons the frame too.
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b0[0] ^ b0[0] ^ (8'h3C >> i) & 1'b1;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        chk("pre_rst busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst busy_next", int'(busy), 0);
        chk("rst data", int'(data), 0);
        rst = 1'b0;
        last_good = 8'h00;
        idle(20);
        chk("rst no_event", evq.size() - ev_rd, 0);
        send_frame(8'hC3, 1'b1, n_start);
        expect_event("after_rst C3", n_start, 1'b1, 8'hC3, gc);
        $display("reset_mid_frame then C3 start=%0d event_cycle=%0d data=%02h", n_start, gc, data);
        last_good = 8'hC3;
        idle(5);

        for (int i = 0; i < 25; i++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 5) != 0);
            send_frame(rb, rstop, n_start);
            if (rstop) last_good = rb;
            expect_event($sformatf("rand%0d", i), n_start, rstop, last_good, gc);
            $display("rand%0d byte=%02h stop=%0d start=%0d event_cycle=%0d data=%02h",
                     i, rb, rstop, n_start, gc, data);
            if (rstop) begin
                idle($urandom_range(0, 12));
            end else begin
                hold_low($urandom_range(0, 30));
                idle($urandom_range(4, 15));
            end
        end

        idle(20);
        chk("final no_stray_event", evq.size() - ev_rd, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
